seg7_scan_reader: RTL
=====================

# seg7_scan_reader

Reads back a time-multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and recovers the hexadecimal value each digit shows. It sits beside the display path of the clock and is the read-side counterpart of the hex-to-7-segment encoder. Typical uses are self-check and loop-back of the displayed time, and observation of an external display driver. Each digit is captured only after its pattern has been stable for a set number of cycles, so scan transitions and ghosting are filtered out.

## Interface
- `DIGITS`, default 4: number of multiplexed digits.
- `STABLE`, default 3 (minimum 2): consecutive cycles an `{an, seg}` sample must hold before capture.

- `clk` in 1: system clock; everything samples on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous clear of `value`, `dig_ok`, frame tracking and the stability counter.
- `seg` in 7: segment lines `{a,b,c,d,e,f,g}`, active-high.
- `an` in DIGITS: digit strobes, active-high, one-hot when valid.
- `value` out 4*DIGITS: recovered nibbles; digit i is `value[4i+3:4i]`.
- `dig_ok` out DIGITS: digit i last showed a legal hex glyph.
- `frame_valid` out 1: one-cycle pulse when every digit has been captured since the last frame.
- `err` out 1: one-cycle pulse when an illegal glyph is captured.
- `bus_err` out 1: one-cycle pulse when a stable `an` is not one-hot.

## Operation
- Glyph set (`seg` value to hex digit):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
  - 00 is blank.
  - Every other pattern is illegal.
- Stability tracker:
  - `{an, seg}` is registered every cycle.
  - Counter `cnt` (range 0..STABLE) counts consecutive cycles on which the sample equals the previous one.
  - `cnt` is 1 on a change and saturates at STABLE.
- Capture happens exactly once per stable run, on the edge where `cnt` reaches STABLE. There is no re-capture while the run continues.
- Capture actions:
  - `an` == 0: ignored; no capture and no error (display off).
  - `an` not one-hot (two or more bits set): `bus_err` pulses; no other state changes.
  - `an` one-hot at bit i with a legal glyph: the nibble is written, `dig_ok[i]` is set, `seen[i]` is set.
  - Blank glyph: nibble is kept, `dig_ok[i]` is cleared, `seen[i]` is set, no `err`.
  - Illegal glyph: nibble is kept, `dig_ok[i]` is cleared, `seen[i]` is set, `err` pulses.
- Frame completion: when `seen` becomes all ones, `frame_valid` pulses and `seen` clears on the same edge. Recapturing an already-seen digit inside a frame overwrites its nibble and does not complete the frame early.
- `clr` has priority over capture on the same edge.
- Reset values: `value`=0, `dig_ok`=0, `frame_valid`=0, `err`=0, `bus_err`=0, `seen`=0, `cnt`=0, sample registers=0.
- Reset asserted mid-run aborts any pending capture. Counting restarts from 1 after release.

## Timing
- Latency: with inputs set up before edge k and held through edge k+STABLE-1, the outputs update after edge k+STABLE-1. For STABLE=3 that is after the 3rd edge.
- `frame_valid`, `err` and `bus_err` are registered, high for exactly one cycle, and coincide with the `value`/`dig_ok` update of the capturing edge.
- A run shorter than STABLE cycles is never captured.
- A change on `an` alone, or on `seg` alone, restarts the run.

## Structure
- Package `seg7_pkg` holds:
  - the 16 glyph constants `SEG_0`..`SEG_F`;
  - `SEG_BLANK`;
  - the glyph encoding function.
  The same constants are shared with the encoder.
- One combinational sub-module, `seg7_glyph_decode`: 7-bit pattern in; outputs 4-bit nibble, `legal` and `blank`.
- The top module contains the sample registers, stability counter, one-hot check, capture logic and the `seen`/frame tracker.

## Test plan
- Reset: hold `rst_n` low with random inputs → all outputs 0. After release, `an`=0 for 10 cycles → no pulses.
- Single digit: `an`=0001, `seg`=7E held 13 cycles → `value[3:0]`=0 and `dig_ok[0]`=1 after the 3rd edge; exactly one capture.
- Full frame: digits 0..3 show 30, 6D, 79, 33, each for 4 cycles → `value`=16'h4321, `dig_ok`=1111, one `frame_valid` pulse on the 4th capture.
- Glitch filter: digit 1 shows 7F for 2 cycles, then 70 for 3 cycles → nibble 1 = 7; no capture of 8.
- Illegal and blank glyphs:
  - Digit 2 shows 01 → `err` pulse, `dig_ok[2]`=0, nibble unchanged.
  - Digit 2 shows 00 → `dig_ok[2]`=0, no `err`.
- Bus error, reset and clear:
  - `an`=0011 stable for 3 cycles → one `bus_err` pulse, nothing captured.
  - `rst_n` low on cycle 2 of a run → no capture.
  - `clr` coinciding with a capture → the capture is dropped.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants and the hex-to-glyph encoding function.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-hex decoder: flags legal hex glyphs and the blank pattern.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    nibble_o = 4'h0;
    legal_o  = 1'b1;
    blank_o  = 1'b0;
    case (pattern_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed 7-segment bus: each {an, seg} sample is captured once
// after it has held for STABLE cycles, and per-digit hex values are recovered.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dig_ok,
  output logic                  frame_valid,
  output logic                  err,
  output logic                  bus_err
);

  localparam int              CW      = $clog2(STABLE + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE);

  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dig_ok_q, dig_ok_d;
  logic [DIGITS-1:0]   seen_q, seen_d, seen_next;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic                bus_err_q, bus_err_d;

  logic       same, capture, onehot;
  logic [3:0] nibble;
  logic       legal, blank;

  seg7_glyph_decode u_decode (
    .pattern_i (seg),
    .nibble_o  (nibble),
    .legal_o   (legal),
    .blank_o   (blank)
  );

  assign same    = (an == an_q) && (seg == seg_q);
  assign onehot  = (an != '0) && ((an & (an - 1'b1)) == '0);

  always_comb begin
    if (!same)               cnt_d = CW'(1);
    else if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
    else                     cnt_d = cnt_q + CW'(1);
  end

  // Fires only on the edge the counter arrives at STABLE, so a long run captures once.
  assign capture = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

  always_comb begin
    value_d   = value_q;
    dig_ok_d  = dig_ok_q;
    seen_d    = seen_q;
    seen_next = seen_q | an;
    frame_d   = 1'b0;
    err_d     = 1'b0;
    bus_err_d = 1'b0;
    if (clr) begin
      value_d  = '0;
      dig_ok_d = '0;
      seen_d   = '0;
    end else if (capture && (an != '0)) begin
      if (!onehot) begin
        bus_err_d = 1'b1;
      end else begin
        if (legal) begin
          for (int i = 0; i < DIGITS; i++)
            if (an[i]) value_d[4*i +: 4] = nibble;
          dig_ok_d = dig_ok_q | an;
        end else begin
          dig_ok_d = dig_ok_q & ~an;
          err_d    = !blank;
        end
        if (&seen_next) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_next;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q      <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      dig_ok_q  <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      an_q      <= an;
      seg_q     <= seg;
      cnt_q     <= clr ? '0 : cnt_d;
      value_q   <= value_d;
      dig_ok_q  <= dig_ok_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign value       = value_q;
  assign dig_ok      = dig_ok_q;
  assign frame_valid = frame_q;
  assign err         = err_q;
  assign bus_err     = bus_err_q;

endmodule
